mem_wb_writeback: RTL and testbench

Final stage of the pipelined RV32 core. Captures MEM-stage results through a valid/ready handshake, selects and aligns the writeback value (ALU result, sign/zero-extended load data, or PC+4), and drives the write port of the integer register file. Holds one entry, supports hold and flush, suppresses writes to x0, and keeps a retired-instruction counter.

---
 rtl/mem_wb_writeback.sv | 130 +++++++++++++
 tb/tb_mem_wb_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: final RV32 pipeline stage. Holds one MEM-stage entry,
// forms the writeback value (ALU, extended load, PC+4), drives the register
// file write port, and counts retired entries.
// Ports: clk, reset_n (async, active-low); in_valid/in_ready handshake;
//   in_reg_write, in_rd, in_wb_sel, in_funct3, in_alu_result, in_load_data,
//   in_pc_plus4 entry fields; hold, flush control;
//   reg_write, write_reg, write_data register-file port; retire_count.
// Option: define WB_FORWARD_EN to add fwd_valid/fwd_rd/fwd_data bypass ports.
module mem_wb_writeback #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_reg_write,
    input  logic [4:0]   in_rd,
    input  logic [1:0]   in_wb_sel,
    input  logic [2:0]   in_funct3,
    input  logic [N-1:0] in_alu_result,
    input  logic [N-1:0] in_load_data,
    input  logic [N-1:0] in_pc_plus4,
    input  logic         hold,
    input  logic         flush,
    output logic         reg_write,
    output logic [4:0]   write_reg,
    output logic [N-1:0] write_data,
    output logic [N-1:0] retire_count
`ifdef WB_FORWARD_EN
    ,
    output logic         fwd_valid,
    output logic [4:0]   fwd_rd,
    output logic [N-1:0] fwd_data
`endif
);

    logic         r_valid;
    logic         r_wen;
    logic [4:0]   r_rd;
    logic [N-1:0] r_data;
    logic [N-1:0] r_count;

    logic         w_retire;
    logic         w_capture;
    logic [1:0]   w_off;
    logic [31:0]  w_word;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;
    logic [31:0]  w_ld;
    logic [N-1:0] w_wb;

    // A flushed entry is dropped, never retired, even with hold low.
    assign in_ready  = !r_valid || !hold;
    assign w_retire  = r_valid && !hold && !flush;
    assign w_capture = in_valid && in_ready && !flush;

    // Load alignment is done on a 32-bit view of the memory word.
    assign w_off  = in_alu_result[1:0];
    assign w_word = 32'(in_load_data);
    assign w_half = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_off)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_ld = w_word;
        case (in_funct3)
            3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld = {24'd0, w_byte};
            3'b001:  w_ld = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld = {16'd0, w_half};
            default: w_ld = w_word;
        endcase
    end

    always_comb begin
        w_wb = in_alu_result;
        case (in_wb_sel)
            2'b01:   w_wb = N'(w_ld);
            2'b10:   w_wb = in_pc_plus4;
            default: w_wb = in_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
            r_rd    <= 5'd0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_wen   <= in_reg_write && (in_rd != 5'd0);
            r_rd    <= in_rd;
            r_data  <= w_wb;
        end else if (w_retire) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + N'(1);
        end
    end

    assign reg_write    = w_retire && r_wen;
    assign write_reg    = r_rd;
    assign write_data   = r_data;
    assign retire_count = r_count;

`ifdef WB_FORWARD_EN
    // Bypass ignores hold: a stalled entry is still the youngest value of rd.
    assign fwd_valid = r_valid && r_wen;
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_data;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: scoreboard bench for mem_wb_writeback with a
// queue-based occupancy model and an arithmetic writeback reference.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_load_data, in_pc_plus4;
    logic        hold, flush;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data, retire_count;

    logic        v8, rdy8, rw8;
    logic [4:0]  wr8;
    logic [7:0]  wd8, cnt8;

`ifdef WB_FORWARD_EN
    logic        fwd_valid, fv8;
    logic [4:0]  fwd_rd, fr8;
    logic [31:0] fwd_data;
    logic [7:0]  fd8;
`endif

    always #5 clk = ~clk;

    mem_wb_writeback #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
        .in_alu_result(in_alu_result), .in_load_data(in_load_data),
        .in_pc_plus4(in_pc_plus4), .hold(hold), .flush(flush),
        .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .retire_count(retire_count)
`ifdef WB_FORWARD_EN
        , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
    );

    mem_wb_writeback #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v8), .in_ready(rdy8),
        .in_reg_write(1'b1), .in_rd(5'd3),
        .in_wb_sel(2'b00), .in_funct3(3'b010),
        .in_alu_result(8'h5A), .in_load_data(8'h00),
        .in_pc_plus4(8'h04), .hold(1'b0), .flush(1'b0),
        .reg_write(rw8), .write_reg(wr8),
        .write_data(wd8), .retire_count(cnt8)
`ifdef WB_FORWARD_EN
        , .fwd_valid(fv8), .fwd_rd(fr8), .fwd_data(fd8)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    // Model of the one-entry stage.
    bit          held_v;
    bit          held_w;
    logic [4:0]  held_rd;
    logic [31:0] held_d;
    logic [31:0] model_cnt;

    // Expectations for the current cycle, read by the monitor.
    bit          mon_en = 1'b0;
    bit          exp_rdy;
    bit          exp_wr;
    logic [31:0] exp_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_wb(input logic [1:0] sel,
        input logic [2:0] f3, input logic [31:0] alu,
        input logic [31:0] ld, input logic [31:0] pc);
        int unsigned o;
        logic [31:0] b, h;
        o = alu & 32'd3;
        b = (ld >> (8 * o)) & 32'hFF;
        h = (ld >> (16 * (o / 2))) & 32'hFFFF;
        if (sel == 2'b10) return pc;
        if (sel != 2'b01) return alu;
        case (f3)
            3'b000:  return (b > 32'h7F) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h > 32'h7FFF) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return ld;
        endcase
    endfunction

    task automatic drive_idle();
        in_valid = 0; in_reg_write = 0; in_rd = 0;
        in_wb_sel = 0; in_funct3 = 0; in_alu_result = 0;
        in_load_data = 0; in_pc_plus4 = 0; hold = 0; flush = 0;
    endtask

    task automatic model_clear();
        held_v = 0; held_w = 0; held_rd = 0; held_d = 0;
        model_cnt = 0; exp_q.delete();
        exp_rdy = 1; exp_wr = 0; exp_cnt = 0;
    endtask

    // One cycle of stimulus; the model decides what that cycle does.
    task automatic step(input bit v, input bit rw, input logic [4:0] rd,
        input logic [1:0] sel, input logic [2:0] f3,
        input logic [31:0] alu, input logic [31:0] ld,
        input logic [31:0] pc, input bit h, input bit fl);
        wr_t e;
        @(posedge clk); #1;
        in_valid = v; in_reg_write = rw; in_rd = rd;
        in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu;
        in_load_data = ld; in_pc_plus4 = pc; hold = h; flush = fl;
        exp_cnt = model_cnt;
        exp_rdy = !held_v || !h;
        exp_wr  = 0;
        if (fl) begin
            held_v = 0;
        end else begin
            if (held_v && !h) begin
                model_cnt = model_cnt + 1;
                if (held_w) begin
                    e.rd = held_rd; e.d = held_d;
                    exp_q.push_back(e);
                    exp_wr = 1;
                end
                held_v = 0;
            end
            if (v && exp_rdy) begin
                held_v  = 1;
                held_w  = rw && (rd != 0);
                held_rd = rd;
                held_d  = ref_wb(sel, f3, alu, ld, pc);
            end
        end
    endtask

    task automatic idle(input bit h);
        step(0, 0, 0, 0, 0, 0, 0, 0, h, 0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("retire_count", retire_count, exp_cnt);
            chk("reg_write", {31'd0, reg_write}, {31'd0, exp_wr});
            if (reg_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
                    chk("write_data", write_data, e.d);
                end
            end
        end
    end

    task automatic chk_reset_outs();
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_retire_count", retire_count, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count8", {24'd0, cnt8}, 32'd0);
    endtask

    localparam logic [31:0] LDW = 32'h8070_F0FF;

    initial begin
        reset_n = 0;
        v8 = 0;
        drive_idle();
        model_clear();
        #3;
        chk_reset_outs();
        @(posedge clk); #1;
        reset_n = 1;
        mon_en = 1;

        // ALU entry to x5.
        step(1, 1, 5, 2'b00, 0, 32'h1234_5678, 0, 0, 0, 0);
        idle(0);

        // Loads from one word, back to back.
        step(1, 1, 6, 2'b01, 3'b000, 32'h100, LDW, 0, 0, 0);
        step(1, 1, 7, 2'b01, 3'b100, 32'h101, LDW, 0, 0, 0);
        step(1, 1, 8, 2'b01, 3'b001, 32'h102, LDW, 0, 0, 0);
        step(1, 1, 9, 2'b01, 3'b101, 32'h103, LDW, 0, 0, 0);
        step(1, 1, 10, 2'b01, 3'b010, 32'h101, LDW, 0, 0, 0);
        step(1, 1, 11, 2'b10, 0, 32'h0, 0, 32'h0000_2004, 0, 0);
        idle(0);

        // x0 destination: no write but still retires.
        step(1, 1, 0, 2'b00, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        idle(0);

        // Hold three cycles, then retire and capture together.
        step(1, 1, 12, 2'b00, 0, 32'hAAAA_0001, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 1, 13, 2'b00, 0, 32'hBBBB_0002, 0, 0, 1, 0);
        step(1, 1, 13, 2'b00, 0, 32'hBBBB_0002, 0, 0, 0, 0);
        idle(0);

        // Flush over a held entry and an incoming one.
        step(1, 1, 14, 2'b00, 0, 32'hCCCC_0003, 0, 0, 0, 0);
        step(1, 1, 15, 2'b00, 0, 32'hDDDD_0004, 0, 0, 1, 1);
        idle(1);
        idle(0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 5'($urandom), 2'($urandom), 3'($urandom), $urandom,
                 $urandom, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        end
        idle(0);
        idle(0);

        // Reset pulsed while an entry is held.
        step(1, 1, 20, 2'b00, 0, 32'h7777_0005, 0, 0, 0, 0);
        idle(1);
        mon_en = 0;
        #2;
        reset_n = 0;
        #1;
        chk_reset_outs();
        drive_idle();
        model_clear();
        @(posedge clk); #1;
        reset_n = 1;
        mon_en = 1;
        idle(0);
        idle(0);

        // Counter wrap on the 8-bit build: 256 retires.
        v8 = 1;
        for (int i = 0; i < 256; i++) @(posedge clk);
        #1;
        chk("count8_ff", {24'd0, cnt8}, 32'h0000_00FF);
        v8 = 0;
        @(posedge clk); #1;
        chk("count8_wrap", {24'd0, cnt8}, 32'h0000_0000);

        idle(0);
        chk("queue_drained", exp_q.size(), 32'd0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
